// File: rtl/tmds_decoder_pipelined.sv
// TMDS receive decoder: classifies symbols, recovers data/control bits, tracks disparity and word alignment.
// Optional saturating error counter built when TMDS_DECODER_ERR_CNT_EN is defined; otherwise err_count_o is 0.

package tmds_decoder_pkg;
  typedef logic [9:0] tmds_word_t;
  typedef logic [7:0] tmds_data_t;
  typedef enum logic [1:0] {
    VIDEO_PERIOD   = 2'd0,
    CONTROL_PERIOD = 2'd1,
    AUDIO_PERIOD   = 2'd2,
    DATA_PERIOD    = 2'd3
  } tmds_period_e;

  localparam tmds_word_t CTRL_TOK_00 = 10'b1101010100;
  localparam tmds_word_t CTRL_TOK_01 = 10'b0010101011;
  localparam tmds_word_t CTRL_TOK_10 = 10'b0101010100;
  localparam tmds_word_t CTRL_TOK_11 = 10'b1010101011;
  localparam tmds_word_t GB_AUDIO    = 10'b1011001100;
  localparam tmds_word_t GB_DATA     = 10'b0100110011;
endpackage

module tmds_decoder_pipelined
  import tmds_decoder_pkg::*;
#(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_HOLDOFF  = 16,
  parameter int RD_LIMIT      = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  tmds_word_t   tmds_i,
  output tmds_data_t   data_o,
  output tmds_period_e data_type_o,
  output logic         c0_o,
  output logic         c1_o,
  output logic         disparity_err_o,
  output logic         bitslip_o,
  output logic         locked_o,
  output logic [15:0]  err_count_o
);

  localparam int WIN_W  = $clog2(SEARCH_WINDOW + 1);
  localparam int TOK_W  = $clog2(LOCK_TOKENS + 1);
  localparam int HOLD_W = $clog2(SLIP_HOLDOFF + 1);

  localparam logic signed [7:0] RD_MAX = 8'sd31;
  localparam logic signed [7:0] RD_MIN = -8'sd31;
  localparam logic signed [7:0] RD_HI  = 8'(RD_LIMIT);
  localparam logic signed [7:0] RD_LO  = 8'(-RD_LIMIT);

  typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_HOLD, ST_LOCKED} state_e;

  // Stage 1: classification and popcount
  tmds_period_e w_type;
  logic [1:0]   w_ctl;
  logic [3:0]   w_pop;

  always_comb begin
    w_type = VIDEO_PERIOD;
    w_ctl  = 2'b00;
    case (tmds_i)
      CTRL_TOK_00: begin w_type = CONTROL_PERIOD; w_ctl = 2'b00; end
      CTRL_TOK_01: begin w_type = CONTROL_PERIOD; w_ctl = 2'b01; end
      CTRL_TOK_10: begin w_type = CONTROL_PERIOD; w_ctl = 2'b10; end
      CTRL_TOK_11: begin w_type = CONTROL_PERIOD; w_ctl = 2'b11; end
      GB_AUDIO:    w_type = AUDIO_PERIOD;
      GB_DATA:     w_type = DATA_PERIOD;
      default:     ;
    endcase
  end

  assign w_pop = 4'($countones(tmds_i));

  logic         r_s1_vld;
  tmds_word_t   r_s1_word;
  tmds_period_e r_s1_type;
  logic [1:0]   r_s1_ctl;
  logic [3:0]   r_s1_pop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_vld  <= 1'b0;
      r_s1_word <= '0;
      r_s1_type <= VIDEO_PERIOD;
      r_s1_ctl  <= 2'b00;
      r_s1_pop  <= '0;
    end else begin
      r_s1_vld  <= 1'b1;
      r_s1_word <= tmds_i;
      r_s1_type <= w_type;
      r_s1_ctl  <= w_ctl;
      r_s1_pop  <= w_pop;
    end
  end

  // Stage 2: data recovery and running disparity
  logic [7:0] w_inv;
  logic [7:0] w_dec;

  assign w_inv = r_s1_word[9] ? ~r_s1_word[7:0] : r_s1_word[7:0];

  always_comb begin
    w_dec    = '0;
    w_dec[0] = w_inv[0];
    for (int i = 1; i < 8; i++) begin
      w_dec[i] = w_inv[i] ^ w_inv[i-1] ^ r_s1_word[8];
    end
  end

  logic signed [5:0] r_rd;
  logic signed [7:0] w_rd_ext;
  logic signed [7:0] w_rd_sum;
  logic signed [7:0] w_rd_sat;
  logic [7:0]        w_rd_delta;
  logic              w_err;

  always_comb begin
    w_rd_ext = {{2{r_rd[5]}}, r_rd};
    case (r_s1_type)
      VIDEO_PERIOD: w_rd_delta = {3'b000, r_s1_pop, 1'b0} - 8'd10;
      AUDIO_PERIOD: w_rd_delta = 8'hFE;
      DATA_PERIOD:  w_rd_delta = 8'h02;
      default:      w_rd_delta = 8'h00;
    endcase
    w_rd_sum = w_rd_ext + w_rd_delta;
    if (r_s1_type == CONTROL_PERIOD) w_rd_sat = '0;
    else if (w_rd_sum > RD_MAX)      w_rd_sat = RD_MAX;
    else if (w_rd_sum < RD_MIN)      w_rd_sat = RD_MIN;
    else                             w_rd_sat = w_rd_sum;
  end

  // Error check only once aligned; control words reset disparity so never flag.
  assign w_err = locked_o && (r_s1_type != CONTROL_PERIOD) &&
                 ((w_rd_sat > RD_HI) || (w_rd_sat < RD_LO));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o          <= '0;
      data_type_o     <= CONTROL_PERIOD;
      c0_o            <= 1'b0;
      c1_o            <= 1'b0;
      disparity_err_o <= 1'b0;
      r_rd            <= '0;
    end else if (r_s1_vld) begin
      data_o          <= (r_s1_type == VIDEO_PERIOD) ? w_dec : 8'h00;
      data_type_o     <= r_s1_type;
      c0_o            <= (r_s1_type == CONTROL_PERIOD) & r_s1_ctl[0];
      c1_o            <= (r_s1_type == CONTROL_PERIOD) & r_s1_ctl[1];
      disparity_err_o <= w_err;
      r_rd            <= w_rd_sat[5:0];
    end else begin
      disparity_err_o <= 1'b0;
    end
  end

  // Alignment FSM, fed from stage 1
  state_e              r_state;
  logic [WIN_W-1:0]    r_win;
  logic [TOK_W-1:0]    r_tok;
  logic [HOLD_W-1:0]   r_hold;
  logic                w_is_ctrl;

  assign w_is_ctrl = r_s1_vld && (r_s1_type == CONTROL_PERIOD);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= ST_SEARCH;
      r_win     <= '0;
      r_tok     <= '0;
      r_hold    <= '0;
      bitslip_o <= 1'b0;
      locked_o  <= 1'b0;
    end else begin
      bitslip_o <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_is_ctrl) begin
            r_win <= '0;
            if (r_tok == TOK_W'(LOCK_TOKENS - 1)) begin
              r_state  <= ST_LOCKED;
              locked_o <= 1'b1;
              r_tok    <= '0;
            end else begin
              r_tok <= r_tok + 1'b1;
            end
          end else begin
            r_tok <= '0;
            if (r_win == WIN_W'(SEARCH_WINDOW - 1)) begin
              r_state <= ST_SLIP;
              r_win   <= '0;
            end else begin
              r_win <= r_win + 1'b1;
            end
          end
        end
        ST_SLIP: begin
          bitslip_o <= 1'b1;
          r_hold    <= '0;
          r_state   <= ST_HOLD;
        end
        ST_HOLD: begin
          if (r_hold == HOLD_W'(SLIP_HOLDOFF - 1)) begin
            r_state <= ST_SEARCH;
            r_win   <= '0;
            r_tok   <= '0;
          end else begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          if (w_is_ctrl) begin
            r_win <= '0;
          end else if (r_win == WIN_W'(SEARCH_WINDOW - 1)) begin
            r_state  <= ST_SEARCH;
            locked_o <= 1'b0;
            r_win    <= '0;
            r_tok    <= '0;
          end else begin
            r_win <= r_win + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef TMDS_DECODER_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (r_s1_vld && w_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_count_o = r_err_cnt;
`else
  assign err_count_o = '0;
`endif

endmodule

// File: tb/tb_tmds_decoder_pipelined.sv
// Scoreboard bench for tmds_decoder_pipelined: randomized words checked against a behavioural model.
module tb_tmds_decoder_pipelined;
  import tmds_decoder_pkg::*;

  localparam int SW  = 256;
  localparam int SH  = 16;
  localparam int LT  = 8;
  localparam int RDL = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  tmds_word_t   tmds_i = '0;
  tmds_data_t   data_o;
  tmds_period_e data_type_o;
  logic         c0_o, c1_o, disparity_err_o, bitslip_o, locked_o;
  logic [15:0]  err_count_o;

  tmds_decoder_pipelined #(
    .LOCK_TOKENS(LT), .SEARCH_WINDOW(SW), .SLIP_HOLDOFF(SH), .RD_LIMIT(RDL)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tmds_i(tmds_i),
    .data_o(data_o), .data_type_o(data_type_o), .c0_o(c0_o), .c1_o(c1_o),
    .disparity_err_o(disparity_err_o), .bitslip_o(bitslip_o),
    .locked_o(locked_o), .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   data;
    tmds_period_e typ;
    logic         c0, c1, err, locked;
    logic [15:0]  ecnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic drv_vld = 1'b0;

  // Behavioural model state
  int m_rd = 0, m_tok = 0, m_gap = 0, m_ecnt = 0;
  bit m_locked = 0;

  function automatic tmds_period_e classify(input logic [9:0] w, output logic [1:0] c);
    c = 2'b00;
    if (w == 10'b1101010100) begin c = 2'b00; return CONTROL_PERIOD; end
    if (w == 10'b0010101011) begin c = 2'b01; return CONTROL_PERIOD; end
    if (w == 10'b0101010100) begin c = 2'b10; return CONTROL_PERIOD; end
    if (w == 10'b1010101011) begin c = 2'b11; return CONTROL_PERIOD; end
    if (w == 10'b1011001100) return AUDIO_PERIOD;
    if (w == 10'b0100110011) return DATA_PERIOD;
    return VIDEO_PERIOD;
  endfunction

  // Transmit-side transform; the decoder must invert it exactly.
  function automatic logic [9:0] encode(input logic [7:0] d, input bit xn, input bit inv);
    logic [7:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    return {inv, xn, inv ? ~qm : qm};
  endfunction

  function automatic logic [7:0] decode_search(input logic [9:0] w);
    for (int b = 0; b < 256; b++)
      if (encode(8'(b), w[8], w[9]) == w) return 8'(b);
    return 8'hxx;
  endfunction

  task automatic push_exp(input logic [9:0] w);
    exp_t e;
    logic [1:0] c;
    e.typ    = classify(w, c);
    e.data   = (e.typ == VIDEO_PERIOD) ? decode_search(w) : 8'h00;
    e.c0     = (e.typ == CONTROL_PERIOD) ? c[0] : 1'b0;
    e.c1     = (e.typ == CONTROL_PERIOD) ? c[1] : 1'b0;
    case (e.typ)
      VIDEO_PERIOD:   m_rd = m_rd + 2 * $countones(w) - 10;
      AUDIO_PERIOD:   m_rd = m_rd - 2;
      DATA_PERIOD:    m_rd = m_rd + 2;
      default:        m_rd = 0;
    endcase
    if (m_rd > 31)  m_rd = 31;
    if (m_rd < -31) m_rd = -31;
    e.err = m_locked && (e.typ != CONTROL_PERIOD) && (m_rd > RDL || m_rd < -RDL);
    if (e.err && m_ecnt < 65535) m_ecnt++;
`ifdef TMDS_DECODER_ERR_CNT_EN
    e.ecnt = 16'(m_ecnt);
`else
    e.ecnt = 16'h0;
`endif
    if (m_locked) begin
      if (e.typ == CONTROL_PERIOD) m_gap = 0;
      else begin
        m_gap++;
        if (m_gap == SW) begin m_locked = 0; m_tok = 0; m_gap = 0; end
      end
    end else begin
      if (e.typ == CONTROL_PERIOD) begin
        m_tok++;
        if (m_tok == LT) begin m_locked = 1; m_tok = 0; m_gap = 0; end
      end else m_tok = 0;
    end
    e.locked = m_locked;
    q.push_back(e);
  endtask

  task automatic send(input logic [9:0] w);
    @(negedge clk);
    tmds_i  = w;
    drv_vld = 1'b1;
    push_exp(w);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_data"},  32'(data_o), 32'h0);
    chk({name, "_type"},  32'(data_type_o), 32'(CONTROL_PERIOD));
    chk({name, "_c"},     32'({c1_o, c0_o}), 32'h0);
    chk({name, "_err"},   32'(disparity_err_o), 32'h0);
    chk({name, "_slip"},  32'(bitslip_o), 32'h0);
    chk({name, "_lock"},  32'(locked_o), 32'h0);
    chk({name, "_ecnt"},  32'(err_count_o), 32'h0);
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = 0; m_tok = 0; m_gap = 0; m_ecnt = 0; m_locked = 0;
  endtask

  // Monitor: outputs for a word appear two edges after it is driven.
  initial begin
    logic v1, v2;
    exp_t e;
    v1 = 1'b0; v2 = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        v1 = 1'b0; v2 = 1'b0;
      end else begin
        v2 = v1;
        v1 = drv_vld;
        #1;
        if (v2) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: output present with no expected entry");
          end else begin
            e = q.pop_front();
            if (data_o !== e.data || data_type_o !== e.typ || c0_o !== e.c0 || c1_o !== e.c1 ||
                disparity_err_o !== e.err || locked_o !== e.locked || err_count_o !== e.ecnt) begin
              n_fail++;
              $display("FAIL sb_word t=%0t: got data=%h type=%0d c=%b%b err=%b lock=%b ecnt=%0d, expected data=%h type=%0d c=%b%b err=%b lock=%b ecnt=%0d",
                       $time, data_o, data_type_o, c1_o, c0_o, disparity_err_o, locked_o, err_count_o,
                       e.data, e.typ, e.c1, e.c0, e.err, e.locked, e.ecnt);
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] w;
    #12;
    chk_reset_vals("reset_init");
    @(posedge clk); #2 rst = 1'b0;

    // Acquire lock with eight 00 tokens
    repeat (LT) send(10'b1101010100);

    // Every byte through the encoder transform, with tokens to hold lock
    for (int b = 0; b < 256; b++) begin
      if (b % 32 == 0) send(encode_token($urandom_range(3)));
      send(encode(8'(b), 1'($urandom_range(1)), 1'($urandom_range(1))));
    end
    send(10'b1011001100);
    send(10'b0100110011);

    // Random raw words with periodic tokens
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(9);
      if (i % 50 == 49 || sel == 0) w = encode_token($urandom_range(3));
      else if (sel == 1) w = 10'b1011001100;
      else if (sel == 2) w = 10'b0100110011;
      else w = 10'($urandom);
      send(w);
    end

    // Disparity climb: +6 per word
    send(10'b1101010100);
    repeat (6) send(10'b1111111100);

    // Token on the expiry cycle keeps lock, then a full silent window drops it
    send(10'b1101010100);
    repeat (SW - 1) send(10'h155);
    send(10'b0010101011);
    repeat (SW) send(10'h155);
    repeat (LT) send(10'b0101010100);
    repeat (4) send(encode(8'($urandom), 1'($urandom_range(1)), 1'($urandom_range(1))));

    // Asynchronous reset between edges
    @(negedge clk); #2;
    rst     = 1'b1;
    drv_vld = 1'b0;
    tmds_i  = 10'h155;
    model_reset();
    #1;
    chk_reset_vals("reset_async");

    // Slip: only 0x155 from reset release
    @(posedge clk); @(posedge clk); #2 rst = 1'b0;
    for (int k = 1; k <= 2 * (SW + SH + 1) + 40; k++) begin
      bit exp_slip;
      @(posedge clk); #1;
      exp_slip = (k >= SW + 1) && (((k - (SW + 1)) % (SW + SH + 1)) == 0);
      chk($sformatf("bitslip_k%0d", k), 32'(bitslip_o), 32'(exp_slip));
      if (k == 1 || k % 100 == 0) chk($sformatf("slip_lock_k%0d", k), 32'(locked_o), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  function automatic logic [9:0] encode_token(input int unsigned idx);
    case (idx)
      0:       return 10'b1101010100;
      1:       return 10'b0010101011;
      2:       return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

endmodule
